// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, redirect input and
// instruction-queue enqueue port.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        queue_full;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           queue_full
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           queue_full
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit. Issues one word fetch at a time,
// parks a returned word in a one-entry buffer while the instruction queue is
// full, and squashes in-flight fetches on a redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc;
  logic [31:0] buf_data, buf_pc;
  logic        latch_req, fill_buf, emit_rd, emit_buf;
  logic        vld_q;
  logic [31:0] out_q, out_pc_q;

  // Next state, next pc and the one-cycle action strobes; redirect wins over all.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    latch_req = 1'b0;
    fill_buf  = 1'b0;
    emit_rd   = 1'b0;
    emit_buf  = 1'b0;
    if (bus.redirect_valid) pc_nxt = {bus.redirect_pc[31:2], 2'b00};
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (bus.redirect_valid) begin
          // a grant in the redirect cycle leaves an orphan response to swallow
          if (bus.imem_gnt) state_nxt = DROP;
        end else if (bus.imem_gnt) begin
          state_nxt = WAIT;
          latch_req = 1'b1;
          pc_nxt    = pc + 32'd4;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          state_nxt = bus.imem_rvalid ? REQ : DROP;
        end else if (bus.imem_rvalid) begin
          if (bus.queue_full) begin
            state_nxt = HOLD;
            fill_buf  = 1'b1;
          end else begin
            state_nxt = REQ;
            emit_rd   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          state_nxt = REQ;
        end else if (!bus.queue_full) begin
          state_nxt = REQ;
          emit_buf  = 1'b1;
        end
      end
      DROP: begin
        if (!bus.redirect_valid && bus.imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pc, in-flight address and hold buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= PC_INIT;
      req_pc   <= '0;
      buf_data <= '0;
      buf_pc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (latch_req) req_pc <= pc;
      if (fill_buf) begin
        buf_data <= bus.imem_rdata;
        buf_pc   <= req_pc;
      end
    end
  end

  // Registered enqueue strobe and payload toward the instruction queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      out_q    <= '0;
      out_pc_q <= '0;
    end else begin
      vld_q <= emit_rd | emit_buf;
      if (emit_rd) begin
        out_q    <= bus.imem_rdata;
        out_pc_q <= req_pc;
      end else if (emit_buf) begin
        out_q    <= buf_data;
        out_pc_q <= buf_pc;
      end
    end
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = vld_q;
  assign bus.instr_out   = out_q;
  assign bus.instr_pc    = out_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level model of the fetch unit.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();
  instruction_fetch_if bus2 ();

  instruction_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_cmp = 0;
  int n_err = 0;

  // model: next fetch address, one accepted fetch in flight (maybe orphaned),
  // one parked word, and the enqueue expected after the last edge
  bit          m_started, m_pend, m_orphan, m_held, m_vld;
  logic [31:0] m_pc, m_pend_pc, m_held_w, m_held_pc, m_out, m_out_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_req();
    return m_started && !m_pend && !m_held;
  endfunction

  task automatic model_reset();
    m_started = 0; m_pend = 0; m_orphan = 0; m_held = 0; m_vld = 0;
    m_pc = 32'h0;
  endtask

  task automatic check_model();
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req()});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_vld});
    if (m_vld) begin
      chk("instr_out", bus.instr_out, m_out);
      chk("instr_pc", bus.instr_pc, m_out_pc);
    end
  endtask

  // one clock: drive at negedge, model the edge, check at the next negedge
  task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                      input bit rdir, input logic [31:0] rpc, input bit qf);
    bit acc, ret, nv;
    logic [31:0] no, npc;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd;
    bus.redirect_valid = rdir; bus.redirect_pc = rpc; bus.queue_full = qf;
    @(posedge clk);
    nv = 0; no = 0; npc = 0;
    if (!m_started) begin
      m_started = 1;
      if (rdir) m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      acc = m_req() && g;
      ret = m_pend && rv;
      if (rdir) begin
        m_pc = rpc & 32'hFFFF_FFFC;
        m_held = 0;
        if (m_pend && !m_orphan) begin
          if (ret) m_pend = 0; else m_orphan = 1;
        end
        if (acc) begin m_pend = 1; m_orphan = 1; end
      end else if (acc) begin
        m_pend = 1; m_orphan = 0; m_pend_pc = m_pc; m_pc = m_pc + 32'd4;
      end else if (ret) begin
        m_pend = 0;
        if (!m_orphan) begin
          if (qf) begin m_held = 1; m_held_w = rd; m_held_pc = m_pend_pc; end
          else begin nv = 1; no = rd; npc = m_pend_pc; end
        end
      end else if (m_held && !qf) begin
        m_held = 0; nv = 1; no = m_held_w; npc = m_held_pc;
      end
    end
    m_vld = nv;
    if (nv) begin m_out = no; m_out_pc = npc; end
    @(negedge clk);
    check_model();
  endtask

  // asynchronous reset pulse starting mid low-phase; outputs must clear at once
  task automatic do_reset();
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.queue_full = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst imem_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst imem_addr", bus.imem_addr, 32'h0);
    chk("rst instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst instr_out", bus.instr_out, 32'h0);
    chk("rst instr_pc", bus.instr_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit g, rv, rdir, qf;
    logic [31:0] rpc;
    bus2.imem_gnt = 1; bus2.imem_rvalid = 1; bus2.imem_rdata = 32'h1234_5678;
    bus2.redirect_valid = 0; bus2.redirect_pc = 0; bus2.queue_full = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // first fetch after reset, plus the wrapping-reset-pc instance alongside
    step(0, 0, 0, 0, 0, 0);
    chk("w addr", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("w req", {31'b0, bus2.imem_req}, 32'h1);
    step(1, 0, 0, 0, 0, 0);
    chk("w req in wait", {31'b0, bus2.imem_req}, 32'h0);
    step(0, 1, 32'hE3A0_0001, 0, 0, 0);
    chk("first valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("first out", bus.instr_out, 32'hE3A0_0001);
    chk("first pc", bus.instr_pc, 32'h0);
    chk("first next addr", bus.imem_addr, 32'h4);
    chk("w valid", {31'b0, bus2.instr_valid}, 32'h1);
    chk("w pc", bus2.instr_pc, 32'hFFFF_FFFC);
    chk("w out", bus2.instr_out, 32'h1234_5678);
    chk("w next addr", bus2.imem_addr, 32'h0);
    bus2.imem_gnt = 0;

    // three back-to-back fetches
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 32'hA000_0000 + k, 0, 0, 0);
      chk("b2b pc", bus.instr_pc, 32'(k * 4));
    end
    step(0, 0, 0, 0, 0, 0);
    chk("b2b single pulse", {31'b0, bus.instr_valid}, 32'h0);

    // queue full at return, held three cycles
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hCAFE_0001, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 1);
      chk("hold no req", {31'b0, bus.imem_req}, 32'h0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("hold release out", bus.instr_out, 32'hCAFE_0001);

    // redirect while waiting, then the stale return
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100, 0);
    step(0, 1, 32'hDEAD_0000, 0, 0, 0);
    chk("redir drop valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("redir addr", bus.imem_addr, 32'h100);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0100, 0, 0, 0);
    chk("redir first pc", bus.instr_pc, 32'h100);

    // redirect together with a grant orphans that request
    step(1, 0, 0, 1, 32'h200, 0);
    chk("orphan no req", {31'b0, bus.imem_req}, 32'h0);
    step(0, 1, 32'hDEAD_0001, 0, 0, 0);
    chk("orphan addr", bus.imem_addr, 32'h200);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0200, 0, 0, 0);
    chk("orphan next pc", bus.instr_pc, 32'h200);

    // misaligned redirect near the top of memory, then pc wrap
    step(0, 0, 0, 1, 32'hFFFF_FFFE, 0);
    chk("align addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap addr", bus.imem_addr, 32'h0);
    step(0, 1, 32'h5555_AAAA, 0, 0, 0);
    chk("wrap pc", bus.instr_pc, 32'hFFFF_FFFC);

    // reset with a fetch in flight, stray return after release
    step(1, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 1, 32'hBAD0_0000, 0, 0, 0);
    step(0, 1, 32'hBAD0_0001, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        g    = m_req() ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 15);
        rv   = m_pend ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
        qf   = $urandom_range(0, 99) < 30;
        rdir = $urandom_range(0, 99) < 7;
        rpc  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                           : $urandom;
        // a return in the orphan-drain state must not coincide with a redirect,
        // or the single outstanding response would be lost for good
        if (m_pend && m_orphan && rv) rdir = 0;
        step(g, rv, $urandom, rdir, rpc, qf);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle (imem_req & imem_gnt = accepted).
REQ-007 imem_rvalid  input  1  read data returned; at most one outstanding request.
REQ-008 imem_rdata  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  branch/exception redirect, single-cycle pulse.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 queue_full  input  1  downstream instruction queue cannot accept an enqueue.
REQ-012 instr_valid  output  1  registered one-cycle enqueue strobe to the instruction queue.
REQ-013 instr_out  output  32  fetched instruction, valid when instr_valid=1.
REQ-014 instr_pc  output  32  address of instr_out, valid when instr_valid=1.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, HOLD, DROP; imem_req SHALL be 1 exactly in REQ.
REQ-016 imem_addr SHALL equal the internal pc register; pc[1:0] SHALL always be 2'b00.
REQ-017 IDLE SHALL move to REQ unconditionally on the first clock after reset release.
REQ-018 REQ: on imem_gnt -> WAIT, latch pc into req_pc, pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 32'h0); without gnt stay in REQ with imem_addr stable.
REQ-019 WAIT: on imem_rvalid with queue_full=0 -> REQ, next cycle instr_valid=1, instr_out=imem_rdata, instr_pc=req_pc.
REQ-020 WAIT: on imem_rvalid with queue_full=1 -> HOLD, capture imem_rdata and req_pc in a one-entry buffer.
REQ-021 HOLD: when queue_full=0 -> REQ, next cycle instr_valid=1 carrying the buffered word and its pc; while queue_full=1 stay, no request issued.
REQ-022 instr_valid SHALL be 1 for exactly one cycle per delivered instruction and never while queue_full was 1 in the issuing cycle.
REQ-023 Latency: gnt in cycle N, rvalid in cycle M>N, instr_valid in cycle M+1 (queue not full).
REQ-024 redirect_valid SHALL take priority over every other event; pc <= {redirect_pc[31:2],2'b00}.
REQ-025 Redirect in REQ without gnt -> stay REQ; with simultaneous gnt -> DROP (accepted old request is orphaned).
REQ-026 Redirect in WAIT without rvalid -> DROP; with simultaneous rvalid -> REQ, data discarded.
REQ-027 Redirect in HOLD -> REQ, buffered word discarded; redirect in DROP -> stay DROP; in IDLE -> REQ.
REQ-028 DROP: on imem_rvalid discard data -> REQ; imem_req=0 throughout.
REQ-029 No instr_valid SHALL be produced in the cycle after a redirect for a pre-redirect fetch.
REQ-030 imem_rvalid outside WAIT/DROP SHALL be ignored.

Reset
REQ-031 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, buffer cleared.
REQ-032 Reset assertion mid-transaction SHALL abandon any outstanding request immediately; no instr_valid after release until a new fetch completes.

Verification
REQ-033 Reset release, gnt=1, rvalid 1 cycle later, rdata 0xE3A00001 -> instr_valid pulse, instr_out=0xE3A00001, instr_pc=0x0; next imem_addr=0x4.
REQ-034 Three back-to-back fetches, queue_full=0 -> instr_pc 0x0,0x4,0x8 in order, one pulse each.
REQ-035 rvalid while queue_full=1 held 3 cycles -> no pulse, imem_req=0; on queue_full=0 one pulse with held data.
REQ-036 redirect_valid to 0x100 in WAIT, rvalid next cycle -> data dropped, next imem_addr=0x100, first instr_pc=0x100.
REQ-037 redirect with simultaneous gnt, then rvalid -> discarded; following fetch at redirect target.
REQ-038 RESET_PC=0xFFFFFFFC, one fetch completes -> instr_pc=0xFFFFFFFC, next imem_addr=0x0.
